vga_fb_arbiter: RTL and testbench
=================================

Name: vga_fb_arbiter

Overview:
Shares one single-port frame-buffer RAM between the VGA scan-out reader and CPU pixel writes. The VGA read path has priority so pixels are fetched on time. CPU writes are posted into a small FIFO and drained in any cycle the reader leaves free. A starvation guard forces a write slot when the FIFO has waited too long. Sits between the processor's memory-mapped VGA store path, the VGA sync/pixel-fetch logic and the frame-buffer RAM.

Parameters:
ADDR_W, 18, frame-buffer word address width (covers 400x400 pixels)
DATA_W, 8, pixel word width
FIFO_DEPTH, 4, posted-write FIFO entries; must be a power of two, >= 2
STARVE_MAX, 64, consecutive cycles a non-empty FIFO may be denied before a write is forced

Ports:
clk  in  1  system clock; the only clock
reset  in  1  synchronous, active-high reset
pix_req  in  1  VGA fetch request for pix_addr this cycle
pix_addr  in  ADDR_W  VGA fetch address
pix_data  out  DATA_W  fetched pixel; equals mem_rdata
pix_valid  out  1  pix_data is valid for the request granted in the previous cycle
pix_miss  out  1  one-cycle pulse: the previous cycle's pix_req was denied
cpu_we  in  1  CPU write strobe; accepted only when cpu_ready=1
cpu_addr  in  ADDR_W  CPU write address
cpu_wdata  in  DATA_W  CPU write data
cpu_ready  out  1  FIFO not full
wr_drop  out  1  sticky: a cpu_we arrived while cpu_ready=0; cleared only by reset
fifo_count  out  $clog2(FIFO_DEPTH)+1  FIFO occupancy
mem_addr  out  ADDR_W  RAM address
mem_we  out  1  RAM write enable
mem_wdata  out  DATA_W  RAM write data
mem_rdata  in  DATA_W  RAM read data, valid one cycle after the address is presented

Behaviour:
Reset values: pix_valid=0, pix_miss=0, wr_drop=0, FIFO empty, fifo_count=0, cpu_ready=1, starve counter=0, grant=GNT_NONE.
Grant is decided each cycle combinationally. The RAM signals are driven in the same cycle:
- force = (starve counter == STARVE_MAX) and FIFO non-empty.
- If force: GNT_WR.
- Else if pix_req: GNT_RD.
- Else if FIFO non-empty: GNT_WR.
- Else: GNT_NONE.
RAM drive per grant:
- GNT_RD: mem_addr=pix_addr, mem_we=0.
- GNT_WR: mem_addr and mem_wdata come from the FIFO head, mem_we=1; the FIFO pops.
- GNT_NONE: mem_we=0, mem_addr holds its previous value.
Read timing:
- pix_valid is registered (grant was GNT_RD). pix_data=mem_rdata, so read latency is exactly 1 cycle.
- pix_miss is registered: pix_req was high and the grant was not GNT_RD.
Starve counter:
- Increments each cycle the FIFO is non-empty and the grant is not GNT_WR.
- Clears on GNT_WR or when the FIFO is empty.
- Saturates at STARVE_MAX.
- Worst-case write wait is STARVE_MAX+1 cycles.
FIFO:
- Push when cpu_we and cpu_ready; pop on GNT_WR. Writes are applied in FIFO order.
- cpu_ready = (count != FIFO_DEPTH), computed from the current count, not the next count. A push while full is rejected even if a pop happens in the same cycle, and wr_drop sets.
- Push and pop in the same cycle with 0<count<FIFO_DEPTH: count unchanged.
- Push into an empty FIFO: the entry is eligible for grant the next cycle, with no same-cycle bypass.
Pointers wrap modulo FIFO_DEPTH.
No read-after-write forwarding: a VGA read of an address with a pending write returns the old RAM contents. This is acceptable as a one-frame artifact.
Reset mid-operation: pending writes are discarded and any in-flight read's pix_valid is suppressed on the next cycle.

Decomposition:
Package vga_fb_pkg holds:
- grant_t enum {GNT_NONE, GNT_RD, GNT_WR}
- default ADDR_W/DATA_W constants
- an ADDR_W-based helper for the pixel-count limit
Sub-module vga_wr_fifo: parameterised synchronous FIFO with push/pop, full/empty and count. The arbiter FSM, starve counter and RAM muxing stay in vga_fb_arbiter.

Test Plan:
1. Read latency. Reset, then pix_req=1 with pix_addr=0x00010 for 1 cycle, RAM preloaded 0xA5 -> next cycle pix_valid=1, pix_data=0xA5, mem_we never high.
2. Idle drain. pix_req=0; three back-to-back cpu_we to addr 5,6,7 with data 1,2,3 -> mem_we pulses on 3 consecutive cycles starting the cycle after the first push, in order; fifo_count returns to 0.
3. Full FIFO. Hold pix_req=1 continuously; issue 5 CPU writes -> cpu_ready=0 after the 4th, 5th rejected, wr_drop=1, fifo_count=4.
4. Starvation. Continue scenario 3 -> after 64 denied cycles a forced write occurs (mem_we=1). pix_miss pulses the next cycle with pix_valid=0; starve counter clears; the next forced write comes 65 cycles later.
5. Full with simultaneous pop. Count=4, pix_req=0, cpu_we=1 -> pop occurs, push rejected, count=3, wr_drop=1.
6. Reset mid-operation. Assert reset with 2 entries pending and a read just granted -> next cycle pix_valid=0, fifo_count=0, cpu_ready=1, mem_we=0.

Source files
------------

// File: rtl/vga_fb_arbiter_pkg.sv
// Shared types and constants for the frame-buffer arbiter.
package vga_fb_pkg;

    typedef enum logic [1:0] {
        GNT_NONE,
        GNT_RD,
        GNT_WR
    } grant_t;

    localparam int VGA_ADDR_W = 18;
    localparam int VGA_DATA_W = 8;
    localparam int FB_PIXELS  = 400 * 400;

    // Number of pixel words an address bus of width aw can reach.
    function automatic longint unsigned pix_limit(input int aw);
        return longint'(1) << aw;
    endfunction

endpackage

// File: rtl/vga_fb_arbiter_if.sv
// Bundles the VGA fetch, CPU store and frame-buffer RAM signals.
interface vga_fb_if
    import vga_fb_pkg::*;
#(
    parameter int ADDR_W     = VGA_ADDR_W,
    parameter int DATA_W     = VGA_DATA_W,
    parameter int FIFO_DEPTH = 4
);
    localparam int CW = $clog2(FIFO_DEPTH) + 1;

    logic              pix_req;
    logic [ADDR_W-1:0] pix_addr;
    logic [DATA_W-1:0] pix_data;
    logic              pix_valid;
    logic              pix_miss;
    logic              cpu_we;
    logic [ADDR_W-1:0] cpu_addr;
    logic [DATA_W-1:0] cpu_wdata;
    logic              cpu_ready;
    logic              wr_drop;
    logic [CW-1:0]     fifo_count;
    logic [ADDR_W-1:0] mem_addr;
    logic              mem_we;
    logic [DATA_W-1:0] mem_wdata;
    logic [DATA_W-1:0] mem_rdata;

    // Surrounding system: VGA fetch logic, CPU store path and the RAM.
    modport master (
        output pix_req, pix_addr, cpu_we, cpu_addr, cpu_wdata, mem_rdata,
        input  pix_data, pix_valid, pix_miss, cpu_ready, wr_drop, fifo_count,
               mem_addr, mem_we, mem_wdata
    );

    // The arbiter itself.
    modport slave (
        input  pix_req, pix_addr, cpu_we, cpu_addr, cpu_wdata, mem_rdata,
        output pix_data, pix_valid, pix_miss, cpu_ready, wr_drop, fifo_count,
               mem_addr, mem_we, mem_wdata
    );

endinterface

// File: rtl/vga_fb_arbiter_wr_fifo.sv
// Posted-write FIFO: synchronous, power-of-two depth, pointers wrap naturally.
module vga_wr_fifo #(
    parameter int W     = 26,
    parameter int DEPTH = 4,
    localparam int PW   = $clog2(DEPTH),
    localparam int CW   = PW + 1
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          push_i,
    input  logic [W-1:0]  wdata_i,
    input  logic          pop_i,
    output logic [W-1:0]  rdata_o,
    output logic          full_o,
    output logic          empty_o,
    output logic [CW-1:0] count_o
);
    logic [W-1:0]  mem_q [DEPTH];
    logic [PW-1:0] wr_ptr_q, rd_ptr_q;
    logic [CW-1:0] count_q;
    logic          do_push, do_pop;

    assign full_o  = (count_q == CW'(DEPTH));
    assign empty_o = (count_q == '0);
    assign count_o = count_q;
    assign rdata_o = mem_q[rd_ptr_q];
    assign do_push = push_i && !full_o;
    assign do_pop  = pop_i && !empty_o;

    // Entry storage; contents need no reset since count gates visibility.
    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_ptr_q] <= wdata_i;
    end

    // Pointers and occupancy.
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
            count_q <= count_q + CW'(do_push) - CW'(do_pop);
        end
    end

endmodule

// File: rtl/vga_fb_arbiter.sv
// Single-port frame-buffer arbiter: VGA reads win, CPU writes drain through
// a posted FIFO, and a starvation counter forces a write slot eventually.
module vga_fb_arbiter
    import vga_fb_pkg::*;
#(
    parameter int ADDR_W     = VGA_ADDR_W,
    parameter int DATA_W     = VGA_DATA_W,
    parameter int FIFO_DEPTH = 4,
    parameter int STARVE_MAX = 64
) (
    input  logic   clk,
    input  logic   reset,
    vga_fb_if.slave bus
);
    localparam int CW = $clog2(FIFO_DEPTH) + 1;
    localparam int SW = $clog2(STARVE_MAX + 1);

    grant_t            gnt_d, gnt_q;
    logic [SW-1:0]     starve_d, starve_q;
    logic [ADDR_W-1:0] mem_addr_q;
    logic              pix_miss_d, pix_miss_q;
    logic              wr_drop_q;
    logic              force_wr, push, pop;
    logic              fifo_full, fifo_empty;
    logic [CW-1:0]     fifo_count;
    logic [ADDR_W-1:0] head_addr;
    logic [DATA_W-1:0] head_data;

    // Ready reflects the current count, so a push while full is lost even
    // when the same cycle pops.
    assign bus.cpu_ready  = !fifo_full;
    assign push           = bus.cpu_we && bus.cpu_ready;
    assign pop            = (gnt_d == GNT_WR);
    assign bus.fifo_count = fifo_count;

    vga_wr_fifo #(
        .W     (ADDR_W + DATA_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .reset   (reset),
        .push_i  (push),
        .wdata_i ({bus.cpu_addr, bus.cpu_wdata}),
        .pop_i   (pop),
        .rdata_o ({head_addr, head_data}),
        .full_o  (fifo_full),
        .empty_o (fifo_empty),
        .count_o (fifo_count)
    );

    // Grant decision and starvation bookkeeping for this cycle.
    always_comb begin
        gnt_d    = GNT_NONE;
        starve_d = starve_q;
        force_wr = (starve_q == SW'(STARVE_MAX)) && !fifo_empty;
        if (force_wr)          gnt_d = GNT_WR;
        else if (bus.pix_req)  gnt_d = GNT_RD;
        else if (!fifo_empty)  gnt_d = GNT_WR;

        if (fifo_empty || gnt_d == GNT_WR)   starve_d = '0;
        else if (starve_q != SW'(STARVE_MAX)) starve_d = starve_q + 1'b1;

        pix_miss_d = bus.pix_req && (gnt_d != GNT_RD);
    end

    // RAM port mux; the address parks on its last value when idle.
    always_comb begin
        bus.mem_we    = 1'b0;
        bus.mem_addr  = mem_addr_q;
        bus.mem_wdata = head_data;
        case (gnt_d)
            GNT_RD: bus.mem_addr = bus.pix_addr;
            GNT_WR: begin
                bus.mem_addr = head_addr;
                bus.mem_we   = 1'b1;
            end
            default: ;
        endcase
    end

    // Grant history, starve counter and sticky status.
    always_ff @(posedge clk) begin
        if (reset) begin
            gnt_q      <= GNT_NONE;
            starve_q   <= '0;
            mem_addr_q <= '0;
            pix_miss_q <= 1'b0;
            wr_drop_q  <= 1'b0;
        end else begin
            gnt_q      <= gnt_d;
            starve_q   <= starve_d;
            mem_addr_q <= bus.mem_addr;
            pix_miss_q <= pix_miss_d;
            if (bus.cpu_we && !bus.cpu_ready) wr_drop_q <= 1'b1;
        end
    end

    // RAM read data arrives one cycle after the granted address.
    assign bus.pix_valid = (gnt_q == GNT_RD);
    assign bus.pix_data  = bus.mem_rdata;
    assign bus.pix_miss  = pix_miss_q;
    assign bus.wr_drop   = wr_drop_q;

endmodule

// File: tb/tb_vga_fb_arbiter.sv
// Self-checking bench: RAM model plus a write scoreboard checked on mem_we.
module tb_vga_fb_arbiter;
    import vga_fb_pkg::*;

    localparam int AW = 18;
    localparam int DW = 8;
    localparam int FD = 4;
    localparam int SM = 64;

    typedef struct packed {
        logic [AW-1:0] a;
        logic [DW-1:0] d;
    } wr_t;

    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    vga_fb_if #(.ADDR_W(AW), .DATA_W(DW), .FIFO_DEPTH(FD)) bus ();

    vga_fb_arbiter #(
        .ADDR_W(AW), .DATA_W(DW), .FIFO_DEPTH(FD), .STARVE_MAX(SM)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    logic [DW-1:0] ram [0:(1<<AW)-1];
    wr_t exp_q[$];
    int  n_checks = 0;
    int  n_fail   = 0;
    int  cyc      = 0;
    bit  mon_en   = 0;

    // Synchronous single-port RAM, read-first.
    always @(posedge clk) begin
        if (bus.mem_we) ram[bus.mem_addr] <= bus.mem_wdata;
        bus.mem_rdata <= ram[bus.mem_addr];
    end

    always @(posedge clk) cyc <= cyc + 1;

    // Every RAM write must match the oldest accepted CPU write.
    always @(negedge clk) begin
        if (mon_en && !reset && bus.mem_we) begin
            wr_t e;
            n_checks++;
            if (exp_q.size() == 0) begin
                n_fail++;
                $display("FAIL wr_order: unexpected write addr=%h data=%h, required no write",
                         bus.mem_addr, bus.mem_wdata);
            end else begin
                e = exp_q.pop_front();
                if ({bus.mem_addr, bus.mem_wdata} !== e) begin
                    n_fail++;
                    $display("FAIL wr_order: got addr=%h data=%h, required addr=%h data=%h",
                             bus.mem_addr, bus.mem_wdata, e.a, e.d);
                end
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic cpu(input bit we, input logic [AW-1:0] a, input logic [DW-1:0] d);
        bus.cpu_we    = we;
        bus.cpu_addr  = a;
        bus.cpu_wdata = d;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        bus.pix_req = 0; bus.pix_addr = '0;
        cpu(0, '0, '0);
        repeat (2) tick();
        @(negedge clk);
        n_checks += 6;
        if (bus.pix_valid !== 1'b0) begin n_fail++; $display("FAIL rst_pix_valid: got %b, required 0", bus.pix_valid); end
        if (bus.pix_miss !== 1'b0) begin n_fail++; $display("FAIL rst_pix_miss: got %b, required 0", bus.pix_miss); end
        if (bus.wr_drop !== 1'b0) begin n_fail++; $display("FAIL rst_wr_drop: got %b, required 0", bus.wr_drop); end
        if (bus.fifo_count !== 0) begin n_fail++; $display("FAIL rst_count: got %0d, required 0", bus.fifo_count); end
        if (bus.cpu_ready !== 1'b1) begin n_fail++; $display("FAIL rst_ready: got %b, required 1", bus.cpu_ready); end
        if (bus.mem_we !== 1'b0) begin n_fail++; $display("FAIL rst_mem_we: got %b, required 0", bus.mem_we); end
        tick();
        reset = 1'b0;
        mon_en = 1;
    endtask

    task automatic test_read_latency();
        ram[16] = 8'hA5;
        bus.pix_req = 1; bus.pix_addr = 18'h00010;
        @(negedge clk);
        n_checks += 2;
        if (bus.mem_we !== 1'b0) begin n_fail++; $display("FAIL rd_mem_we: got %b, required 0", bus.mem_we); end
        if (bus.mem_addr !== 18'h00010) begin n_fail++; $display("FAIL rd_addr: got %h, required 00010", bus.mem_addr); end
        tick();
        bus.pix_req = 0;
        @(negedge clk);
        n_checks += 3;
        if (bus.pix_valid !== 1'b1) begin n_fail++; $display("FAIL rd_valid: got %b, required 1", bus.pix_valid); end
        if (bus.pix_data !== 8'hA5) begin n_fail++; $display("FAIL rd_data: got %h, required a5", bus.pix_data); end
        if (bus.pix_miss !== 1'b0) begin n_fail++; $display("FAIL rd_miss: got %b, required 0", bus.pix_miss); end
        tick();
        @(negedge clk);
        n_checks++;
        if (bus.pix_valid !== 1'b0) begin n_fail++; $display("FAIL rd_valid_drop: got %b, required 0", bus.pix_valid); end
        tick();
    endtask

    task automatic test_idle_drain();
        bus.pix_req = 0;
        for (int i = 0; i < 5; i++) begin
            if (i < 3) begin
                cpu(1, AW'(5 + i), DW'(1 + i));
                exp_q.push_back({AW'(5 + i), DW'(1 + i)});
            end else begin
                cpu(0, '0, '0);
            end
            @(negedge clk);
            n_checks++;
            if (bus.mem_we !== ((i >= 1 && i <= 3) ? 1'b1 : 1'b0)) begin
                n_fail++;
                $display("FAIL drain_we_c%0d: got %b, required %b", i, bus.mem_we, (i >= 1 && i <= 3));
            end
            tick();
        end
        @(negedge clk);
        n_checks += 2;
        if (bus.fifo_count !== 0) begin n_fail++; $display("FAIL drain_count: got %0d, required 0", bus.fifo_count); end
        if (exp_q.size() != 0) begin n_fail++; $display("FAIL drain_left: got %0d pending, required 0", exp_q.size()); end
        tick();
    endtask

    task automatic test_full_starve();
        int c_push = 0;
        int c_f1 = 0;
        int t;
        bus.pix_req = 1; bus.pix_addr = 18'h00020;
        for (int i = 0; i < 5; i++) begin
            cpu(1, AW'(18'h100 + i), DW'(8'h10 + i));
            @(negedge clk);
            if (i == 0) c_push = cyc;
            if (i < 4) exp_q.push_back({AW'(18'h100 + i), DW'(8'h10 + i)});
            n_checks++;
            if (bus.cpu_ready !== (i < 4)) begin
                n_fail++;
                $display("FAIL full_ready_w%0d: got %b, required %b", i, bus.cpu_ready, (i < 4));
            end
            tick();
        end
        cpu(0, '0, '0);
        @(negedge clk);
        n_checks += 2;
        if (bus.wr_drop !== 1'b1) begin n_fail++; $display("FAIL full_drop: got %b, required 1", bus.wr_drop); end
        if (bus.fifo_count !== 4) begin n_fail++; $display("FAIL full_count: got %0d, required 4", bus.fifo_count); end

        t = 0;
        while (bus.mem_we !== 1'b1 && t < 200) begin tick(); @(negedge clk); t++; end
        n_checks += 2;
        if (cyc - c_push != SM + 1) begin
            n_fail++; $display("FAIL starve_first: forced write %0d cycles after push, required %0d", cyc - c_push, SM + 1);
        end
        if (bus.pix_valid !== 1'b1) begin n_fail++; $display("FAIL starve_prev_valid: got %b, required 1", bus.pix_valid); end
        c_f1 = cyc;
        tick();
        @(negedge clk);
        n_checks += 3;
        if (bus.pix_miss !== 1'b1) begin n_fail++; $display("FAIL starve_miss: got %b, required 1", bus.pix_miss); end
        if (bus.pix_valid !== 1'b0) begin n_fail++; $display("FAIL starve_valid: got %b, required 0", bus.pix_valid); end
        if (bus.fifo_count !== 3) begin n_fail++; $display("FAIL starve_count: got %0d, required 3", bus.fifo_count); end

        t = 0;
        while (bus.mem_we !== 1'b1 && t < 200) begin tick(); @(negedge clk); t++; end
        n_checks++;
        if (cyc - c_f1 != SM + 1) begin
            n_fail++; $display("FAIL starve_second: gap %0d cycles, required %0d", cyc - c_f1, SM + 1);
        end
        tick();
        bus.pix_req = 0;
        repeat (4) tick();
        @(negedge clk);
        n_checks += 2;
        if (bus.fifo_count !== 0) begin n_fail++; $display("FAIL starve_drain: got %0d, required 0", bus.fifo_count); end
        if (exp_q.size() != 0) begin n_fail++; $display("FAIL starve_left: got %0d pending, required 0", exp_q.size()); end
        tick();
    endtask

    task automatic test_full_pop();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        exp_q.delete();
        @(negedge clk);
        n_checks++;
        if (bus.wr_drop !== 1'b0) begin n_fail++; $display("FAIL pop_drop_clear: got %b, required 0", bus.wr_drop); end
        tick();
        bus.pix_req = 1;
        for (int i = 0; i < 4; i++) begin
            cpu(1, AW'(18'h200 + i), DW'(8'h40 + i));
            exp_q.push_back({AW'(18'h200 + i), DW'(8'h40 + i)});
            tick();
        end
        bus.pix_req = 0;
        cpu(1, 18'h2FF, 8'hEE);
        @(negedge clk);
        n_checks += 3;
        if (bus.cpu_ready !== 1'b0) begin n_fail++; $display("FAIL pop_ready: got %b, required 0", bus.cpu_ready); end
        if (bus.mem_we !== 1'b1) begin n_fail++; $display("FAIL pop_we: got %b, required 1", bus.mem_we); end
        if (bus.wr_drop !== 1'b0) begin n_fail++; $display("FAIL pop_drop_early: got %b, required 0", bus.wr_drop); end
        tick();
        cpu(0, '0, '0);
        @(negedge clk);
        n_checks += 2;
        if (bus.fifo_count !== 3) begin n_fail++; $display("FAIL pop_count: got %0d, required 3", bus.fifo_count); end
        if (bus.wr_drop !== 1'b1) begin n_fail++; $display("FAIL pop_drop: got %b, required 1", bus.wr_drop); end
        repeat (4) tick();
        @(negedge clk);
        n_checks += 2;
        if (bus.fifo_count !== 0) begin n_fail++; $display("FAIL pop_drain: got %0d, required 0", bus.fifo_count); end
        if (exp_q.size() != 0) begin n_fail++; $display("FAIL pop_left: got %0d pending, required 0", exp_q.size()); end
        tick();
    endtask

    task automatic test_reset_mid();
        bus.pix_req = 1; bus.pix_addr = 18'h00030;
        for (int i = 0; i < 2; i++) begin
            cpu(1, AW'(18'h300 + i), DW'(8'h70 + i));
            tick();
        end
        cpu(0, '0, '0);
        reset = 1'b1;
        @(negedge clk);
        n_checks += 2;
        if (bus.fifo_count !== 2) begin n_fail++; $display("FAIL mid_count_pre: got %0d, required 2", bus.fifo_count); end
        if (bus.mem_we !== 1'b0) begin n_fail++; $display("FAIL mid_rd_grant: got mem_we=%b, required 0", bus.mem_we); end
        tick();
        reset = 1'b0;
        bus.pix_req = 0;
        @(negedge clk);
        n_checks += 4;
        if (bus.pix_valid !== 1'b0) begin n_fail++; $display("FAIL mid_valid: got %b, required 0", bus.pix_valid); end
        if (bus.fifo_count !== 0) begin n_fail++; $display("FAIL mid_count: got %0d, required 0", bus.fifo_count); end
        if (bus.cpu_ready !== 1'b1) begin n_fail++; $display("FAIL mid_ready: got %b, required 1", bus.cpu_ready); end
        if (bus.mem_we !== 1'b0) begin n_fail++; $display("FAIL mid_we: got %b, required 0", bus.mem_we); end
        tick();
        @(negedge clk);
        n_checks++;
        if (bus.mem_we !== 1'b0) begin n_fail++; $display("FAIL mid_discard: got mem_we=%b, required 0", bus.mem_we); end
        tick();
    endtask

    initial begin
        bus.pix_req = 0; bus.pix_addr = '0;
        bus.cpu_we = 0; bus.cpu_addr = '0; bus.cpu_wdata = '0;
        test_reset();
        test_read_latency();
        test_idle_drain();
        test_full_starve();
        test_full_pop();
        test_reset_mid();
        n_checks++;
        if (exp_q.size() != 0) begin n_fail++; $display("FAIL final_left: got %0d pending, required 0", exp_q.size()); end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
